sram_test_seq: RTL

Self-checking test sequencer that sits directly upstream of the SRAM controller and drives its 32-bit bus-register inputs (`enable`, `send`, `sta_addr`, `area_cfg`, `op_cfg`) in place of the bus master. It consumes the controller's `outp_data`, `outp_addr` and `status`, and runs a two-pass data-background test: fill the whole SRAM with `seed`, read back every address, then repeat with `~seed`. It reports an error count, the first failing address and a pass flag to the LED/debug logic.

---
 rtl/sram_test_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_test_seq.sv
// rtl/sram_test_seq.sv - two-pass data-background SRAM test sequencer driving the controller registers
// Optional watchdog: define SRAM_SEQ_TIMEOUT_EN.
module sram_test_seq #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       enable,
  output logic [31:0]       send,
  output logic [31:0]       sta_addr,
  output logic [31:0]       area_cfg,
  output logic [31:0]       op_cfg,
  input  logic [31:0]       outp_data,
  input  logic [31:0]       outp_addr,
  input  logic [31:0]       status
);

  localparam logic [7:0]        ST_CONFIG = 8'h01;
  localparam logic [7:0]        ST_IDLE   = 8'h02;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_ARM, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT, S_CHK, S_NEXT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [31:0]       enable_q, enable_d;
  logic [31:0]       send_q, send_d;
  logic [31:0]       area_cfg_q, area_cfg_d;
  logic              tog_q, tog_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              pass_idx_q, pass_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              left_q, left_d;

  logic              status_idle;
  logic [DATA_W-1:0] pat;
  logic              mismatch;
  logic              wd_expire;
  logic              unused_in;

  assign status_idle = (status[7:0] == ST_IDLE);
  assign pat         = pass_idx_q ? ~seed_q : seed_q;
  assign mismatch    = (outp_data[DATA_W-1:0] != pat) || (outp_addr[ADDR_W-1:0] != addr_q);
  assign unused_in   = ^{outp_data[31:DATA_W], outp_addr[31:ADDR_W], status[31:8]};

`ifdef SRAM_SEQ_TIMEOUT_EN
  // Watchdog restarts on every state change and only runs in the controller wait states.
  logic [15:0] wd_q, wd_d;
  logic        in_wait;

  assign in_wait   = (state_q == S_CFG) || (state_q == S_ARM) ||
                     (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
  assign wd_expire = in_wait && (wd_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) wd_d = 16'd0;
    else if (in_wait)       wd_d = wd_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= 16'd0;
    else       wd_q <= wd_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      err_cnt_q        <= 16'd0;
      first_err_addr_q <= '0;
      enable_q         <= 32'd0;
      send_q           <= 32'd0;
      area_cfg_q       <= 32'd0;
      tog_q            <= 1'b0;
      seed_q           <= '0;
      pass_idx_q       <= 1'b0;
      addr_q           <= '0;
      left_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      enable_q         <= enable_d;
      send_q           <= send_d;
      area_cfg_q       <= area_cfg_d;
      tog_q            <= tog_d;
      seed_q           <= seed_d;
      pass_idx_q       <= pass_idx_d;
      addr_q           <= addr_d;
      left_q           <= left_d;
    end
  end

  // Wait states need the controller to leave IDLE before its return counts as completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CFG;
      S_CFG:     if (status[7:0] == ST_CONFIG) state_d = S_ARM;
      S_ARM:     if (status_idle) state_d = S_WR;
      S_WR:      state_d = S_WR_WAIT;
      S_WR_WAIT: if (left_q && status_idle) state_d = S_RD;
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: if (left_q && status_idle) state_d = S_CHK;
      S_CHK:     state_d = (addr_q == LAST_ADDR) ? S_NEXT : S_RD;
      S_NEXT:    state_d = pass_idx_q ? S_DONE : S_WR;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (wd_expire) state_d = S_DONE;
  end

  always_comb begin
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    enable_d         = enable_q;
    send_d           = send_q;
    area_cfg_d       = area_cfg_q;
    tog_d            = tog_q;
    seed_d           = seed_q;
    pass_idx_d       = pass_idx_q;
    addr_d           = addr_q;
    left_d           = left_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          timeout_d        = 1'b0;
          err_cnt_d        = 16'd0;
          first_err_addr_d = '0;
          pass_idx_d       = 1'b0;
          seed_d           = seed;
          area_cfg_d       = 32'((2 ** ADDR_W) - 1);
          enable_d         = 32'd0;
        end
      end
      S_CFG: enable_d = 32'd0;
      S_ARM: enable_d = 32'h1;
      S_WR: begin
        send_d = {~tog_q, {(31 - DATA_W){1'b0}}, pat};
        tog_d  = ~tog_q;
        left_d = 1'b0;
        addr_d = '0;
      end
      S_WR_WAIT: if (!status_idle) left_d = 1'b1;
      S_RD: begin
        enable_d = 32'h3;
        send_d   = {~tog_q, {(31 - ADDR_W){1'b0}}, addr_q};
        tog_d    = ~tog_q;
        left_d   = 1'b0;
      end
      S_RD_WAIT: if (!status_idle) left_d = 1'b1;
      S_CHK: begin
        if (mismatch) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (err_cnt_q == 16'd0)    first_err_addr_d = addr_q;
        end
        if (addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);
      end
      S_NEXT: begin
        if (!pass_idx_q) begin
          pass_idx_d = 1'b1;
          enable_d   = 32'h1;
        end
      end
      default: ;
    endcase
    // Results are registered on DONE entry so they hold after returning to IDLE.
    if (state_d == S_DONE && state_q != S_DONE) begin
      enable_d = 32'd0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      if (wd_expire) timeout_d = 1'b1;
      pass_d   = (err_cnt_d == 16'd0) && !timeout_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
  assign enable         = enable_q;
  assign send           = send_q;
  assign sta_addr       = 32'd0;
  assign area_cfg       = area_cfg_q;
  assign op_cfg         = 32'd0;

endmodule
